// File: rtl/cp0_tlb_regfile.sv
// MIPS-style CP0 register file: TLB staging registers, timer, exception and interrupt state.
// Define CP0_RANDOM_WIRED_EN to enable a decrementing Random register bounded by a writable Wired.
module cp0_tlb_regfile #(
  parameter int          TLB_ENTRIES = 32,
  parameter int          IDX_W       = 5,
  parameter logic [31:0] PRID_VAL    = 32'h004C0102
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mtc0_we,
  input  logic [4:0]       mtc0_addr,
  input  logic [31:0]      mtc0_data,
  input  logic [4:0]       mfc0_addr,
  output logic [31:0]      mfc0_data,
  input  logic             stall,
  input  logic             flush,
  input  logic [5:0]       hw_int,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [31:0]      exc_pc,
  input  logic             exc_bd,
  input  logic [31:0]      exc_badva,
  input  logic             eret,
  input  logic             tlbp_we,
  input  logic             tlbp_hit,
  input  logic [IDX_W-1:0] tlbp_idx,
  input  logic             tlbr_we,
  input  logic [31:0]      tlbr_hi,
  input  logic [31:0]      tlbr_lo0,
  input  logic [31:0]      tlbr_lo1,
  input  logic [31:0]      tlbr_mask,
  output logic [IDX_W-1:0] index_o,
  output logic [IDX_W-1:0] random_o,
  output logic [31:0]      entryhi_o,
  output logic [31:0]      entrylo0_o,
  output logic [31:0]      entrylo1_o,
  output logic [31:0]      pagemask_o,
  output logic [31:0]      status_o,
  output logic [31:0]      cause_o,
  output logic [31:0]      epc_o,
  output logic             int_req
);
  localparam logic [IDX_W-1:0] RAND_TOP  = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [31:0]      LO_MASK   = 32'h03FFFFFF;
  localparam logic [31:0]      PM_MASK   = 32'h01FFE000;
  localparam logic [31:0]      HI_MASK   = 32'hFFFFE0FF;
  localparam logic [31:0]      ST_MASK   = 32'h0040FF03;
  localparam logic [31:0]      CONFIG_VAL = 32'h00008000;

  logic             index_p_q, index_p_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [31:0]      entrylo0_q, entrylo0_d, entrylo1_q, entrylo1_d;
  logic [31:0]      pagemask_q, pagemask_d, entryhi_q, entryhi_d;
  logic [31:0]      badva_q, badva_d, count_q, count_d, compare_q, compare_d;
  logic [31:0]      status_q, status_d, epc_q, epc_d;
  logic             tog_q, tog_d, ti_q, ti_d, bd_q, bd_d;
  logic [5:0]       ip_hw_q, ip_hw_d;
  logic [1:0]       ip_sw_q, ip_sw_d;
  logic [4:0]       exccode_q, exccode_d;
  logic [31:0]      count_inc, cause_val, wired_val;
  logic [7:0]       ip_all;
  logic             commit, wr;

`ifdef CP0_RANDOM_WIRED_EN
  logic [IDX_W-1:0] random_q, random_d, wired_q, wired_d;
  assign wired_val = 32'(wired_q);
`else
  logic [IDX_W-1:0] random_q;
  assign random_q  = RAND_TOP;
  assign wired_val = 32'd0;
`endif

  assign commit    = ~(stall | flush);
  assign wr        = mtc0_we & commit;
  assign count_inc = count_q + 32'd1;
  assign ip_all    = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
  assign cause_val = {bd_q, ti_q, 14'd0, ip_all, 1'b0, exccode_q, 2'b00};

  always_comb begin
    index_p_d  = index_p_q;  index_d    = index_q;
    entrylo0_d = entrylo0_q; entrylo1_d = entrylo1_q;
    pagemask_d = pagemask_q; entryhi_d  = entryhi_q;
    badva_d    = badva_q;    compare_d  = compare_q;
    status_d   = status_q;   epc_d      = epc_q;
    bd_d       = bd_q;       exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;    ip_hw_d    = hw_int;
    ti_d       = ti_q;
    tog_d      = ~tog_q;
    count_d    = count_q;
`ifdef CP0_RANDOM_WIRED_EN
    wired_d    = wired_q;
    random_d   = (random_q <= wired_q) ? RAND_TOP : random_q - 1'b1;
`endif
    if (tog_q) begin
      count_d = count_inc;
      if (count_inc == compare_q) ti_d = 1'b1;
    end

    // Lowest priority first; each later stage overwrites only the fields it owns.
    if (wr) begin
      unique case (mtc0_addr)
        5'd0:  index_d    = mtc0_data[IDX_W-1:0];
        5'd2:  entrylo0_d = mtc0_data & LO_MASK;
        5'd3:  entrylo1_d = mtc0_data & LO_MASK;
        5'd5:  pagemask_d = mtc0_data & PM_MASK;
`ifdef CP0_RANDOM_WIRED_EN
        5'd6: begin
          wired_d  = mtc0_data[IDX_W-1:0];
          random_d = RAND_TOP;
        end
`endif
        5'd9: begin
          count_d = mtc0_data;
          tog_d   = 1'b0;
        end
        5'd10: entryhi_d  = mtc0_data & HI_MASK;
        5'd11: begin
          compare_d = mtc0_data;
          ti_d      = 1'b0;
        end
        5'd12: status_d   = mtc0_data & ST_MASK;
        5'd13: ip_sw_d    = mtc0_data[9:8];
        5'd14: epc_d      = mtc0_data;
        default: ;
      endcase
    end

    if (tlbp_we && commit) begin
      index_p_d = ~tlbp_hit;
      if (tlbp_hit) index_d = tlbp_idx;
    end
    if (tlbr_we && commit) begin
      entryhi_d  = tlbr_hi & HI_MASK;
      entrylo0_d = tlbr_lo0 & LO_MASK;
      entrylo1_d = tlbr_lo1 & LO_MASK;
      pagemask_d = tlbr_mask & PM_MASK;
    end

    if (eret && commit) status_d[1] = 1'b0;

    if (exc_valid && commit) begin
      // Nested exceptions keep the original return address and delay-slot flag.
      if (!status_q[1]) begin
        epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
        bd_d  = exc_bd;
      end
      exccode_d   = exc_code;
      status_d[1] = 1'b1;
      if (exc_code inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}) badva_d = exc_badva;
      if (exc_code inside {5'd1, 5'd2, 5'd3}) entryhi_d[31:13] = exc_badva[31:13];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index_p_q  <= 1'b0;          index_q    <= '0;
      entrylo0_q <= '0;            entrylo1_q <= '0;
      pagemask_q <= '0;            entryhi_q  <= '0;
      badva_q    <= '0;            count_q    <= '0;
      compare_q  <= '0;            status_q   <= 32'h00400000;
      epc_q      <= '0;            tog_q      <= 1'b0;
      ti_q       <= 1'b0;          bd_q       <= 1'b0;
      ip_hw_q    <= '0;            ip_sw_q    <= '0;
      exccode_q  <= '0;
`ifdef CP0_RANDOM_WIRED_EN
      random_q   <= RAND_TOP;      wired_q    <= '0;
`endif
    end else begin
      index_p_q  <= index_p_d;     index_q    <= index_d;
      entrylo0_q <= entrylo0_d;    entrylo1_q <= entrylo1_d;
      pagemask_q <= pagemask_d;    entryhi_q  <= entryhi_d;
      badva_q    <= badva_d;       count_q    <= count_d;
      compare_q  <= compare_d;     status_q   <= status_d;
      epc_q      <= epc_d;         tog_q      <= tog_d;
      ti_q       <= ti_d;          bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;       ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
`ifdef CP0_RANDOM_WIRED_EN
      random_q   <= random_d;      wired_q    <= wired_d;
`endif
    end
  end

  always_comb begin
    mfc0_data = 32'd0;
    unique case (mfc0_addr)
      5'd0:  mfc0_data = {index_p_q, {(31 - IDX_W){1'b0}}, index_q};
      5'd1:  mfc0_data = 32'(random_q);
      5'd2:  mfc0_data = entrylo0_q;
      5'd3:  mfc0_data = entrylo1_q;
      5'd5:  mfc0_data = pagemask_q;
      5'd6:  mfc0_data = wired_val;
      5'd8:  mfc0_data = badva_q;
      5'd9:  mfc0_data = count_q;
      5'd10: mfc0_data = entryhi_q;
      5'd11: mfc0_data = compare_q;
      5'd12: mfc0_data = status_q;
      5'd13: mfc0_data = cause_val;
      5'd14: mfc0_data = epc_q;
      5'd15: mfc0_data = PRID_VAL;
      5'd16: mfc0_data = CONFIG_VAL;
      default: ;
    endcase
  end

  assign index_o    = index_q;
  assign random_o   = random_q;
  assign entryhi_o  = entryhi_q;
  assign entrylo0_o = entrylo0_q;
  assign entrylo1_o = entrylo1_q;
  assign pagemask_o = pagemask_q;
  assign status_o   = status_q;
  assign cause_o    = cause_val;
  assign epc_o      = epc_q;
  assign int_req    = status_q[0] & ~status_q[1] & |(ip_all & status_q[15:8]);
endmodule

// File: tb/tb_cp0_tlb_regfile.sv
// Directed bench for cp0_tlb_regfile: register map, masks, timer, exceptions, TLB ops, stall and reset.
module tb_cp0_tlb_regfile;
  logic        clk = 1'b0;
  logic        rst, mtc0_we, stall, flush, exc_valid, exc_bd, eret;
  logic        tlbp_we, tlbp_hit, tlbr_we;
  logic [4:0]  mtc0_addr, mfc0_addr, exc_code, tlbp_idx;
  logic [31:0] mtc0_data, mfc0_data, exc_pc, exc_badva;
  logic [31:0] tlbr_hi, tlbr_lo0, tlbr_lo1, tlbr_mask;
  logic [5:0]  hw_int;
  logic [4:0]  index_o, random_o;
  logic [31:0] entryhi_o, entrylo0_o, entrylo1_o, pagemask_o, status_o, cause_o, epc_o;
  logic        int_req;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  cp0_tlb_regfile dut (
    .clk(clk), .rst(rst), .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data), .stall(stall), .flush(flush), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badva(exc_badva), .eret(eret), .tlbp_we(tlbp_we), .tlbp_hit(tlbp_hit),
    .tlbp_idx(tlbp_idx), .tlbr_we(tlbr_we), .tlbr_hi(tlbr_hi), .tlbr_lo0(tlbr_lo0),
    .tlbr_lo1(tlbr_lo1), .tlbr_mask(tlbr_mask), .index_o(index_o), .random_o(random_o),
    .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
    .pagemask_o(pagemask_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .int_req(int_req)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) begin
      $display("[TB] %s ok: %08h", tag, obs);
    end else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0_addr = a;
    #1;
    chk(tag, mfc0_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1'b1; mtc0_addr = a; mtc0_data = d;
    step();
    mtc0_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mtc0_we = 0; mtc0_addr = 0; mtc0_data = 0; mfc0_addr = 0;
    stall = 0; flush = 0; hw_int = 0; exc_valid = 0; exc_code = 0; exc_pc = 0;
    exc_bd = 0; exc_badva = 0; eret = 0; tlbp_we = 0; tlbp_hit = 0; tlbp_idx = 0;
    tlbr_we = 0; tlbr_hi = 0; tlbr_lo0 = 0; tlbr_lo1 = 0; tlbr_mask = 0;
    step(2);
    chk_reg("rst_status", 5'd12, 32'h00400000);
    chk_reg("rst_random", 5'd1, 32'd31);
    chk_reg("rst_config", 5'd16, 32'h00008000);
    chk_reg("rst_prid", 5'd15, 32'h004C0102);
    chk_reg("rst_cause", 5'd13, 32'h0);
    chk_reg("rst_count", 5'd9, 32'h0);
    chk_reg("rst_index", 5'd0, 32'h0);
    chk("rst_int_req", {31'd0, int_req}, 32'd0);
    rst = 1'b0;

    // Unmapped addresses and write masks
    mtc0(5'd4, 32'hFFFFFFFF);
    chk_reg("unmapped4", 5'd4, 32'h0);
    chk_reg("unmapped7", 5'd7, 32'h0);
    mtc0(5'd10, 32'hFFFFFFFF);
    chk_reg("entryhi_mask", 5'd10, 32'hFFFFE0FF);
    mtc0(5'd12, 32'hFFFFFFFF);
    chk_reg("status_mask", 5'd12, 32'h0040FF03);
    chk("int_req_exl", {31'd0, int_req}, 32'd0);
    mtc0(5'd12, 32'h0);
    mtc0(5'd13, 32'hFFFFFFFF);
    chk_reg("cause_mask", 5'd13, 32'h00000300);
    mtc0(5'd13, 32'h0);

    // Timer: Count reaches 10 after 20 cycles
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    step(16);
    chk_reg("ti_early", 5'd13, 32'h0);
    step(8);
    chk_reg("ti_set", 5'd13, 32'h40008000);
    mtc0(5'd12, 32'h00008001);
    chk("int_req_timer", {31'd0, int_req}, 32'd1);
    mtc0(5'd11, 32'h0000FFFF);
    chk_reg("ti_clear", 5'd13, 32'h0);
    chk("int_req_cleared", {31'd0, int_req}, 32'd0);

    // Hardware interrupt line 0 -> IP2
    hw_int = 6'b000001;
    step();
    chk_reg("ip2", 5'd13, 32'h00000400);
    mtc0(5'd12, 32'h00000401);
    chk("int_req_hw", {31'd0, int_req}, 32'd1);
    hw_int = 6'b0;
    step();
    chk("int_req_hw_off", {31'd0, int_req}, 32'd0);
    mtc0(5'd12, 32'h0);

    // TLB load exception in delay slot, competing mtc0 EPC dropped
    exc_valid = 1; exc_code = 5'd2; exc_pc = 32'h80001004; exc_bd = 1; exc_badva = 32'h00402ABC;
    mtc0(5'd14, 32'h0);
    exc_valid = 0;
    chk_reg("exc_epc", 5'd14, 32'h80001000);
    chk_reg("exc_cause", 5'd13, 32'h80000008);
    chk_reg("exc_badva", 5'd8, 32'h00402ABC);
    chk_reg("exc_entryhi", 5'd10, 32'h004020FF);
    chk_reg("exc_status", 5'd12, 32'h00000002);

    // Nested exception keeps EPC/BD
    exc_valid = 1; exc_code = 5'd5; exc_pc = 32'h00001234; exc_bd = 0; exc_badva = 32'hDEADBEEF;
    step();
    exc_valid = 0;
    chk_reg("nest_epc", 5'd14, 32'h80001000);
    chk_reg("nest_cause", 5'd13, 32'h80000014);
    chk_reg("nest_badva", 5'd8, 32'hDEADBEEF);
    chk_reg("nest_entryhi", 5'd10, 32'h004020FF);
    eret = 1;
    step();
    eret = 0;
    chk_reg("eret_status", 5'd12, 32'h0);

    // TLB probe / read
    tlbp_we = 1; tlbp_hit = 0; tlbp_idx = 5'd9;
    step();
    chk_reg("tlbp_miss", 5'd0, 32'h80000000);
    tlbp_hit = 1; tlbp_idx = 5'd7;
    step();
    chk_reg("tlbp_hit", 5'd0, 32'h00000007);
    tlbp_hit = 0; tlbp_idx = 5'd3;
    step();
    tlbp_we = 0;
    chk_reg("tlbp_miss2", 5'd0, 32'h80000007);
    mtc0(5'd0, 32'hFFFFFFFF);
    chk_reg("index_mask", 5'd0, 32'h8000001F);
    tlbr_we = 1; tlbr_hi = 32'hFFFFFFFF; tlbr_lo0 = 32'hFFFFFFFF;
    tlbr_lo1 = 32'h12345678; tlbr_mask = 32'hFFFFFFFF;
    mtc0(5'd2, 32'h0);
    tlbr_we = 0;
    chk("tlbr_hi", entryhi_o, 32'hFFFFE0FF);
    chk("tlbr_lo0", entrylo0_o, 32'h03FFFFFF);
    chk("tlbr_lo1", entrylo1_o, 32'h02345678);
    chk("tlbr_mask", pagemask_o, 32'h01FFE000);

    // Random / Wired
    mtc0(5'd6, 32'd4);
`ifdef CP0_RANDOM_WIRED_EN
    chk("random_top", 32'(random_o), 32'd31);
    chk_reg("wired_rd", 5'd6, 32'd4);
    step();
    chk("random_30", 32'(random_o), 32'd30);
    step(26);
    chk("random_wired", 32'(random_o), 32'd4);
    step();
    chk("random_wrap", 32'(random_o), 32'd31);
`else
    chk_reg("wired_rd", 5'd6, 32'd0);
    step(5);
    chk("random_const", 32'(random_o), 32'd31);
`endif

    // Count wrap
    mtc0(5'd9, 32'hFFFFFFFF);
    step();
    chk_reg("count_hold", 5'd9, 32'hFFFFFFFF);
    step();
    chk_reg("count_wrap", 5'd9, 32'h0);

    // stall / flush suppress commits
    stall = 1;
    mtc0(5'd12, 32'h0000FF01);
    stall = 0;
    chk_reg("stall_status", 5'd12, 32'h0);
    flush = 1; exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h00000100; exc_bd = 0;
    step();
    flush = 0; exc_valid = 0;
    chk_reg("flush_epc", 5'd14, 32'h80001000);

    // Reset overrides same-cycle commits
    rst = 1; exc_valid = 1;
    mtc0(5'd14, 32'h5);
    rst = 0; exc_valid = 0;
    chk_reg("rst2_status", 5'd12, 32'h00400000);
    chk_reg("rst2_epc", 5'd14, 32'h0);
    chk_reg("rst2_index", 5'd0, 32'h0);
    chk_reg("rst2_entryhi", 5'd10, 32'h0);
    chk_reg("rst2_badva", 5'd8, 32'h0);
    chk_reg("rst2_cause", 5'd13, 32'h0);
    chk_reg("rst2_random", 5'd1, 32'd31);
    chk("rst2_int_req", {31'd0, int_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
